// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch that assembles 32-bit words and hands them to ID
// over a valid/ready handshake. Define IF_ICACHE_EN to add a direct-mapped I-cache.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_IDX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] mem_a,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_din,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] pc,
  output logic [31:0] ins
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] fpc_q, fpc_d;
  logic        replay_q, replay_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic        valid_q, valid_d;

  logic [1:0]  byte_sel;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        fetch_hit;

  // Byte whose data is due this cycle (cnt 1..4 maps to byte 0..3).
  assign byte_sel  = cnt_q[1:0] - 2'd1;
  assign fetch_hit = (state_q == FETCH) && (cnt_q == 3'd0) && cache_hit;

`ifdef IF_ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [31:0]             line_data [LINES];
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [LINES-1:0]        line_valid;
  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    fill;

  assign idx        = fpc_q[ICACHE_IDX_W+1:2];
  assign tag        = fpc_q[31:ICACHE_IDX_W+2];
  assign cache_hit  = line_valid[idx] && (line_tag[idx] == tag);
  assign cache_data = line_data[idx];
  // A line is written only when the last byte lands without a competing jump or stall.
  assign fill       = rdy_in && !jump_en && (state_q == FETCH) && (cnt_q == 3'd4) && !replay_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[idx] <= 1'b1;
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      line_data[idx] <= {mem_din, ins_q[23:0]};
      line_tag[idx]  <= tag;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      fpc_q    <= RESET_PC;
      replay_q <= 1'b0;
      pc_q     <= RESET_PC;
      ins_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fpc_q    <= fpc_d;
      replay_q <= replay_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a hold default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    fpc_d    = fpc_q;
    replay_d = replay_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    valid_d  = valid_q;

    if (!rdy_in) begin
      // Data due during a pause is lost; remember to re-request it on resume.
      if (state_q == FETCH && cnt_q != 3'd0) begin
        replay_d = 1'b1;
      end
    end else if (jump_en) begin
      state_d  = FLUSH;
      cnt_d    = '0;
      fpc_d    = jump_addr & 32'hFFFF_FFFC;
      replay_d = 1'b0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fetch_hit) begin
            state_d = HOLD;
            pc_d    = fpc_q;
            ins_d   = cache_data;
            valid_d = 1'b1;
          end else if (replay_q) begin
            replay_d = 1'b0;
          end else begin
            if (cnt_q != 3'd0) begin
              ins_d[8*byte_sel +: 8] = mem_din;
            end
            if (cnt_q == 3'd4) begin
              state_d = HOLD;
              pc_d    = fpc_q;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            state_d = FETCH;
            fpc_d   = fpc_q + 32'd4;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        FLUSH: begin
          state_d = FETCH;
          cnt_d   = '0;
        end
        default: begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_a     = fpc_q;
    mem_rd_en = 1'b0;
    if (rst_in && rdy_in && state_q == FETCH && !fetch_hit) begin
      if (replay_q) begin
        mem_a     = fpc_q + {30'd0, byte_sel};
        mem_rd_en = 1'b1;
      end else if (cnt_q != 3'd4) begin
        mem_a     = fpc_q + {30'd0, cnt_q[1:0]};
        mem_rd_en = 1'b1;
      end
    end
  end

  assign if_valid = valid_q;
  assign pc       = pc_q;
  assign ins      = ins_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: vector table, directed corner sequences and a randomized run against a
// transaction-level model of the delivered (pc, ins) stream. Honors IF_ICACHE_EN.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a;
  logic        mem_rd_en;
  logic [7:0]  mem_din = 8'h00;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] ins;

  int n_checks = 0;
  int n_err    = 0;

  if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_IDX_W(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .mem_a     (mem_a),
    .mem_rd_en (mem_rd_en),
    .mem_din   (mem_din),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .pc        (pc),
    .ins       (ins)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h0:        return 8'h13;
      32'h1:        return 8'h05;
      32'h2, 32'h3: return 8'h00;
      default:      return 8'(a[7:0] * 8'd7 + a[15:8] + a[31:24] + 8'h21);
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  // One-cycle read latency; cycles without a request return filler so stale data is visible.
  always @(posedge clk_in) mem_din <= mem_rd_en ? byte_at(mem_a) : 8'hEE;

  typedef struct {
    logic        rdy;
    logic        jump;
    logic [31:0] jaddr;
    logic        id;
    logic        exp_valid;
    logic        exp_rd;
    logic [31:0] exp_a;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rdy, input logic jump, input logic [31:0] jaddr,
                              input logic id, input logic valid, input logic rd,
                              input logic [31:0] a, input logic [31:0] p, input logic [31:0] w);
    vec_t v;
    v.rdy = rdy; v.jump = jump; v.jaddr = jaddr; v.id = id;
    v.exp_valid = valid; v.exp_rd = rd; v.exp_a = a; v.exp_pc = p; v.exp_ins = w;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_in = 1'b0; rdy_in = 1'b1; jump_en = 1'b0; id_ready = 1'b0;
    #1;
    check("rst_valid", if_valid, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_ins", ins, 32'h0);
    step();
    step();
    rst_in = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input int max, output int n, output int reqs);
    n = 0;
    reqs = 0;
    while (!if_valid && n < max) begin
      reqs += int'(mem_rd_en);
      step();
      n++;
    end
    check("wait_valid_timeout", if_valid, 1'b1);
  endtask

  // Cycles from the first FETCH cycle after the flush until if_valid, and requests issued.
  task automatic fetch_lat(input logic [31:0] a, output int n, output int reqs);
    jump_en = 1'b1; jump_addr = a;
    step();
    jump_en = 1'b0;
    step();
    wait_valid(20, n, reqs);
    check("lat_pc", pc, a);
    check("lat_ins", ins, word_at(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, reqs, n_hs;
    bit fired, done, saw_c;
    logic [31:0] exp_pc;

    // Reset release, first miss, 10-cycle hold, then the next fetch at fpc+4.
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 0, 1, i, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0513);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 4 + i, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 1, 0, 4, 4, word_at(4));
    add(1, 0, 0, 1, 1, 0, 4, 4, word_at(4));
    add(1, 0, 0, 0, 0, 1, 8, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      rdy_in = vecs[i].rdy; jump_en = vecs[i].jump;
      jump_addr = vecs[i].jaddr; id_ready = vecs[i].id;
      #1;
      check($sformatf("vec%0d_valid", i), if_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_rd_en", i), mem_rd_en, vecs[i].exp_rd);
      check($sformatf("vec%0d_mem_a", i), mem_a, vecs[i].exp_a);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_ins", i), ins, vecs[i].exp_ins);
      end
      step();
    end

    // Jump to an unaligned target while byte 2 is being fetched.
    do_reset();
    step();
    step();
    jump_en = 1'b1; jump_addr = 32'h0000_0103;
    step();
    jump_en = 1'b0;
    #1;
    check("flush_rd_en", mem_rd_en, 1'b0);
    check("flush_mem_a", mem_a, 32'h100);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("jmp_rd_en%0d", k), mem_rd_en, 1'b1);
      check($sformatf("jmp_mem_a%0d", k), mem_a, 32'h100 + k);
    end
    wait_valid(8, n, reqs);
    check("jmp_pc", pc, 32'h100);
    check("jmp_ins", ins, word_at(32'h100));

    // Jump coinciding with the handshake of pc=0x8 wins; 0xC is never fetched.
    do_reset();
    id_ready = 1'b1;
    fired = 0; done = 0; saw_c = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      jump_en = !fired && if_valid && (pc == 32'h8);
      if (jump_en) begin
        jump_addr = 32'h40;
        fired = 1;
      end
      #1;
      if (mem_rd_en && mem_a == 32'hC) saw_c = 1;
      if (fired && !jump_en && if_valid) begin
        done = 1;
        check("hs_jump_pc", pc, 32'h40);
        check("hs_jump_ins", ins, word_at(32'h40));
      end
      step();
    end
    jump_en = 1'b0; id_ready = 1'b0;
    check("hs_jump_fired", fired, 1'b1);
    check("hs_jump_done", done, 1'b1);
    check("no_fetch_0xC", saw_c, 1'b0);

    // Three-cycle pause at cnt=3: byte 2 must be requested again.
    do_reset();
    jump_en = 1'b1; jump_addr = 32'h60;
    step();
    jump_en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 3; k++) begin
      rdy_in = 1'b0;
      #1;
      check($sformatf("stall_rd_en%0d", k), mem_rd_en, 1'b0);
      step();
    end
    rdy_in = 1'b1;
    #1;
    check("reissue_rd_en", mem_rd_en, 1'b1);
    check("reissue_mem_a", mem_a, 32'h62);
    wait_valid(10, n, reqs);
    check("stall_pc", pc, 32'h60);
    check("stall_ins", ins, word_at(32'h60));

    // fpc+4 wraps to zero.
    do_reset();
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFE;
    step();
    jump_en = 1'b0;
    wait_valid(12, n, reqs);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_ins", ins, word_at(32'hFFFF_FFFC));
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    #1;
    check("wrap_rd_en", mem_rd_en, 1'b1);
    check("wrap_mem_a", mem_a, 32'h0);

    // Revisiting 0x20: a hit with the cache, another full miss without it.
    do_reset();
    fetch_lat(32'h20, n, reqs);
    check("miss_latency", n, 5);
    check("miss_reqs", reqs, 4);
    fetch_lat(32'h20, n, reqs);
`ifdef IF_ICACHE_EN
    check("hit_latency", n, 1);
    check("hit_reqs", reqs, 0);
`else
    check("nocache_latency", n, 5);
    check("nocache_reqs", reqs, 4);
`endif
    // A fetch cut short by a jump must not populate a line.
    jump_en = 1'b1; jump_addr = 32'h40;
    step();
    jump_en = 1'b0;
    step();
    step();
    step();
    fetch_lat(32'h40, n, reqs);
    check("aborted_fill_latency", n, 5);
    do_reset();
    fetch_lat(32'h20, n, reqs);
    check("post_reset_latency", n, 5);
    check("post_reset_reqs", reqs, 4);

    // Randomized run: delivered stream must follow pc+4 / jump-target sequencing.
    do_reset();
    exp_pc = 32'h0;
    n_hs = 0;
    for (int k = 0; k < 3000; k++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      id_ready  = 1'($urandom_range(0, 1));
      jump_en   = ($urandom_range(0, 24) == 0);
      jump_addr = $urandom_range(0, 32'h3FF);
      #1;
      if (!rdy_in) begin
        check("rand_paused_rd_en", mem_rd_en, 1'b0);
      end else if (jump_en) begin
        exp_pc = jump_addr & 32'hFFFF_FFFC;
      end else if (if_valid && id_ready) begin
        check("rand_pc", pc, exp_pc);
        check("rand_ins", ins, word_at(exp_pc));
        exp_pc += 32'd4;
        n_hs++;
      end
      step();
    end
    rdy_in = 1'b1; jump_en = 1'b0; id_ready = 1'b0;
    check("rand_progress", n_hs > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 The block SHALL have parameter ICACHE_IDX_W, default 4: I-cache index width, giving 2**ICACHE_IDX_W entries; used only with IF_ICACHE_EN.
REQ-003 The block SHALL have port clk_in, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port rdy_in, input, 1: global enable; when low, all state holds.
REQ-006 The block SHALL have port mem_a, output, 32: byte address to instruction memory.
REQ-007 The block SHALL have port mem_rd_en, output, 1: byte read request to instruction memory.
REQ-008 The block SHALL have port mem_din, input, 8: read byte, valid one cycle after its request.
REQ-009 The block SHALL have port jump_en, input, 1: redirect pulse from EX.
REQ-010 The block SHALL have port jump_addr, input, 32: redirect target.
REQ-011 The block SHALL have port id_ready, input, 1: ID accepts this cycle.
REQ-012 The block SHALL have port if_valid, output, 1: pc/ins hold a valid instruction.
REQ-013 The block SHALL have port pc, output, 32: address of the instruction on ins.
REQ-014 The block SHALL have port ins, output, 32: fetched little-endian instruction word.

Function
REQ-015 The FSM SHALL have states FETCH, HOLD and FLUSH.
REQ-016 In FETCH with byte counter cnt 0..3, the block SHALL drive mem_a=fpc+cnt and mem_rd_en=1.
REQ-017 At cnt 1..4, the block SHALL capture mem_din into ins byte cnt-1; at cnt 4 it SHALL issue no request and SHALL enter HOLD.
REQ-018 Miss latency SHALL be 5 cycles: if_valid goes high exactly 5 cycles after FETCH is entered with cnt=0.
REQ-019 Assembly order SHALL be ins[7:0]=byte at fpc and ins[31:24]=byte at fpc+3.
REQ-020 In HOLD, if_valid SHALL be 1, and pc/ins SHALL stay stable until a handshake (if_valid&&id_ready).
REQ-021 On a handshake, the block SHALL set fpc<=fpc+4 and cnt<=0, clear if_valid, and return to FETCH.
REQ-022 When jump_en=1 in any state, the block SHALL set fpc<={jump_addr[31:2],2'b00}, clear if_valid, set cnt<=0 and enter FLUSH.
REQ-023 When jump_en coincides with a handshake, jump SHALL take priority and the handshake SHALL be dropped, not advancing fpc+4.
REQ-024 FLUSH SHALL last one cycle with mem_rd_en=0, discarding any in-flight byte, then the block SHALL enter FETCH.
REQ-025 When rdy_in=0, the block SHALL hold all registers, drive mem_rd_en=0, and ignore jump_en and id_ready.
REQ-026 When rdy_in returns to 1 with cnt 1..4, the block SHALL reissue byte cnt-1, because the paused memory data is treated as lost.
REQ-027 fpc+4 SHALL wrap modulo 2**32, so 32'hFFFF_FFFC+4 gives 32'h0.
REQ-028 Outside FETCH request cycles, mem_a SHALL be fpc and mem_rd_en SHALL be 0.

Reset
REQ-029 While rst_in=0, the block SHALL force state=FETCH, cnt=0, fpc=RESET_PC, pc=RESET_PC, ins=32'h0 and if_valid=0.
REQ-030 While rst_in=0, the block SHALL also force mem_rd_en=0, mem_a=RESET_PC, and all I-cache valid bits to 0.
REQ-031 Reset SHALL abort any fetch mid-operation with no output side effect.
REQ-032 The first request SHALL occur in the first cycle after rst_in rises with rdy_in=1.

Configuration
REQ-033 With macro IF_ICACHE_EN defined, the block SHALL include a direct-mapped I-cache: index fpc[ICACHE_IDX_W+1:2], tag fpc[31:ICACHE_IDX_W+2], one valid bit per entry.
REQ-034 With IF_ICACHE_EN, on entering FETCH with a hit, the block SHALL go to HOLD next cycle with no memory request (1-cycle latency).
REQ-035 With IF_ICACHE_EN, on a miss, the block SHALL fill the entry when cnt=4 completes; a jump before completion SHALL leave the entry unchanged.
REQ-036 Without IF_ICACHE_EN, the block SHALL have no cache storage, and every fetch SHALL take the 5-cycle path.

Verification
REQ-037 The bench SHALL cover: reset release, mem bytes 0x00..0x03 = 13,05,00,00, id_ready=1 -> if_valid rises at cycle 5, pc=0, ins=32'h0000_0513; next request at mem_a=4.
REQ-038 The bench SHALL cover: id_ready=0 for 10 cycles in HOLD -> pc/ins unchanged, mem_rd_en=0; id_ready=1 -> fetch starts at fpc+4.
REQ-039 The bench SHALL cover: jump_en=1, jump_addr=32'h0000_0103 at cnt=2 -> one FLUSH cycle, then mem_a=0x100..0x103, and if_valid shows pc=0x100.
REQ-040 The bench SHALL cover: jump_en with the handshake at pc=0x8 -> no fetch at 0xC, and the next pc equals jump_addr.
REQ-041 The bench SHALL cover: rdy_in=0 for 3 cycles at cnt=3 -> mem_rd_en=0; after resume, byte 2 at fpc+2 is reissued and ins is correct.
REQ-042 The bench SHALL cover, with IF_ICACHE_EN: loop of jump_en to 0x20 twice -> second visit if_valid 1 cycle after FLUSH exit, no mem_rd_en; rst_in=0 then re-fetch at 0x20 -> 5-cycle miss.
